// File: rtl/demux_dispatch_ctrl.sv
// Round-robin dispatcher steering one valid/ready stream onto a 1-to-4 demux.
// Optional DEMUX_CTRL_STATS_EN adds per-channel transfer and retarget counters.
module demux_dispatch_ctrl #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ch_en,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [1:0]       sel,
`ifdef DEMUX_CTRL_STATS_EN
  output logic [31:0]      stat_cnt,
  output logic [7:0]       retarget_cnt,
`endif
  output logic             busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;
  localparam logic [7:0] TMAX   = 8'(TIMEOUT - 1);

  logic [0:0]       state_q, state_d;
  logic [1:0]       rr_q, rr_d;
  logic [1:0]       tgt_q, tgt_d;
  logic [7:0]       tmr_q, tmr_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             xfer, retgt;

  // First enabled index at or after p (mod 4); dflt when mask is empty.
  function automatic logic [1:0] next_en(
    input logic [1:0] p,
    input logic [3:0] en,
    input logic [1:0] dflt
  );
    logic [1:0] r;
    logic [1:0] idx;
    r = dflt;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (en[idx]) r = idx;
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    tgt_d   = tgt_q;
    tmr_d   = tmr_q;
    hold_d  = hold_q;
    xfer    = 1'b0;
    retgt   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && |ch_en) begin
          hold_d  = in_data;
          tgt_d   = next_en(rr_q, ch_en, rr_q);
          tmr_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (out_ready[tgt_q]) begin
          xfer    = 1'b1;
          rr_d    = tgt_q + 2'd1;
          state_d = S_IDLE;
        end else if (tmr_q == TMAX) begin
          retgt = 1'b1;
          tgt_d = next_en(tgt_q + 2'd1, ch_en, tgt_q);
          tmr_d = '0;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      tgt_q   <= '0;
      tmr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      tgt_q   <= tgt_d;
      tmr_q   <= tmr_d;
      hold_q  <= hold_d;
    end
  end

  // rst_n gates in_ready so nothing is offered while reset is held
  assign in_ready  = rst_n & (state_q == S_IDLE) & (|ch_en);
  assign busy      = (state_q == S_SEND);
  assign out_valid = busy ? (4'b0001 << tgt_q) : 4'b0000;
  assign sel       = tgt_q;
  assign out_data  = hold_q;

`ifdef DEMUX_CTRL_STATS_EN
  logic [3:0][7:0] stat_q;
  logic [7:0]      ret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
      ret_q  <= '0;
    end else begin
      if (xfer && stat_q[tgt_q] != 8'hFF)
        stat_q[tgt_q] <= stat_q[tgt_q] + 8'd1;
      if (retgt && ret_q != 8'hFF)
        ret_q <= ret_q + 8'd1;
    end
  end

  assign stat_cnt     = stat_q;
  assign retarget_cnt = ret_q;
`endif

endmodule
